// File: rtl/interrupt_controller_pkg.sv
// ============================================================================
// Module      : interrupt_controller_pkg
// Description : Shared definitions for the interrupt controller and the
//               InterruptAddressGenerator. Contains cause codes, FSM state
//               encodings and the arbiter result type.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package interrupt_controller_pkg;

    // Cause codes driven on interSel
    localparam logic [2:0] c_CAUSE_NMI    = 3'd0;
    localparam logic [2:0] c_CAUSE_ECALL  = 3'd1;
    localparam logic [2:0] c_CAUSE_EBREAK = 3'd2;
    localparam logic [2:0] c_CAUSE_TMR    = 3'd3;
    localparam logic [2:0] c_CAUSE_INT    = 3'd4;

    // Controller FSM state encodings
    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_REQ     = 2'd1;
    localparam logic [1:0] c_ST_SERVICE = 2'd2;

    // Eligible-source vector bit positions (highest priority at bit 0)
    typedef enum logic [2:0] {
        SRC_NMI    = 3'd0,
        SRC_ECALL  = 3'd1,
        SRC_EBREAK = 3'd2,
        SRC_TMR    = 3'd3,
        SRC_EXT0   = 3'd4,
        SRC_EXT1   = 3'd5
    } src_e;

    // Arbiter result
    typedef struct packed {
        logic       valid;
        logic [2:0] sel;
        logic       num;
    } arb_res_t;

endpackage

`default_nettype wire

// File: rtl/interrupt_controller_if.sv
// ============================================================================
// Module      : interrupt_controller_if
// Description : Bundle between the pipeline (master) and the interrupt
//               controller (slave).
//   Requests   : nmi, ecall, ebreak, tmr_irq, ext_irq[1:0]
//   Enables    : mie, tie, eie
//   Handshake  : take_ack, mret
//   Responses  : interruptF, interSel[2:0], intNum, in_service, pending[4:0]
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface interrupt_controller_if;

    logic       nmi;
    logic       ecall;
    logic       ebreak;
    logic       tmr_irq;
    logic [1:0] ext_irq;
    logic       mie;
    logic       tie;
    logic       eie;
    logic       take_ack;
    logic       mret;

    logic       interruptF;
    logic [2:0] interSel;
    logic       intNum;
    logic       in_service;
    logic [4:0] pending;

    modport master (
        output nmi, ecall, ebreak, tmr_irq, ext_irq,
        output mie, tie, eie, take_ack, mret,
        input  interruptF, interSel, intNum, in_service, pending
    );

    modport slave (
        input  nmi, ecall, ebreak, tmr_irq, ext_irq,
        input  mie, tie, eie, take_ack, mret,
        output interruptF, interSel, intNum, in_service, pending
    );

endinterface

`default_nettype wire

// File: rtl/interrupt_priority_encoder.sv
// ============================================================================
// Module      : interrupt_priority_encoder
// Description : Combinational fixed-priority arbiter over the six eligible
//               request lines NMI > ECALL > EBREAK > TMR > EXT0 > EXT1.
//   i_elig  : eligible sources, bit index per src_e
//   o_res   : valid flag, winning cause code, external line index
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module interrupt_priority_encoder
    import interrupt_controller_pkg::*;
(
    input  wire logic [5:0] i_elig,
    output arb_res_t        o_res
);

    always_comb begin
        o_res = '0;
        if (i_elig[SRC_NMI]) begin
            o_res.valid = 1'b1;
            o_res.sel   = c_CAUSE_NMI;
        end else if (i_elig[SRC_ECALL]) begin
            o_res.valid = 1'b1;
            o_res.sel   = c_CAUSE_ECALL;
        end else if (i_elig[SRC_EBREAK]) begin
            o_res.valid = 1'b1;
            o_res.sel   = c_CAUSE_EBREAK;
        end else if (i_elig[SRC_TMR]) begin
            o_res.valid = 1'b1;
            o_res.sel   = c_CAUSE_TMR;
        end else if (i_elig[SRC_EXT0]) begin
            o_res.valid = 1'b1;
            o_res.sel   = c_CAUSE_INT;
        end else if (i_elig[SRC_EXT1]) begin
            o_res.valid = 1'b1;
            o_res.sel   = c_CAUSE_INT;
            o_res.num   = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/interrupt_controller.sv
// ============================================================================
// Module      : interrupt_controller
// Description : Latches NMI/ECALL/EBREAK/timer events, arbitrates them with
//               the level-sensitive external lines, and runs the
//               IDLE -> REQ -> SERVICE handshake with one level of NMI
//               pre-emption.
//   clk     : system clock, rising edge
//   rst     : synchronous active-high reset
//   irq_if  : slave side of interrupt_controller_if
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module interrupt_controller
    import interrupt_controller_pkg::*;
(
    input  wire logic             clk,
    input  wire logic             rst,
    interrupt_controller_if.slave irq_if
);

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic       r_nmi_q;
    logic [3:0] r_pend;          // {tmr, ebreak, ecall, nmi}
    logic       r_nmi_active;
    logic       r_nmi_preempt;   // NMI interrupted another handler
    logic [2:0] r_inter_sel;
    logic       r_int_num;

    logic [3:0] w_set;
    logic [3:0] w_pend_eff;
    logic [3:0] w_clr;
    logic [1:0] w_ext_req;
    logic       w_in_svc;
    logic [5:0] w_elig;
    arb_res_t   w_arb;
    logic       w_take;
    logic       w_nmi_preempt;
    logic       w_load;

    assign w_set = {irq_if.tmr_irq, irq_if.ebreak, irq_if.ecall,
                    irq_if.nmi & ~r_nmi_q};

    // Events arriving this cycle take part in arbitration immediately so the
    // request appears one cycle after the event is sampled.
    assign w_pend_eff = r_pend | w_set;
    assign w_ext_req  = irq_if.ext_irq & {2{irq_if.eie}};
    assign w_in_svc   = (r_state == c_ST_SERVICE);

    assign w_elig[SRC_NMI]    = w_pend_eff[0];
    assign w_elig[SRC_ECALL]  = w_pend_eff[1] & ~w_in_svc;
    assign w_elig[SRC_EBREAK] = w_pend_eff[2] & ~w_in_svc;
    assign w_elig[SRC_TMR]    = w_pend_eff[3] & irq_if.tie & irq_if.mie & ~w_in_svc;
    assign w_elig[SRC_EXT0]   = w_ext_req[0] & irq_if.mie & ~w_in_svc;
    assign w_elig[SRC_EXT1]   = w_ext_req[1] & irq_if.mie & ~w_in_svc;

    interrupt_priority_encoder u_prio (
        .i_elig (w_elig),
        .o_res  (w_arb)
    );

    assign w_take = (r_state == c_ST_REQ) & irq_if.take_ack;

    // A handler return in the same cycle wins over a fresh NMI; the NMI
    // stays pending and is re-arbitrated from IDLE.
    assign w_nmi_preempt = w_in_svc & ~irq_if.mret & w_elig[SRC_NMI] & ~r_nmi_active;
    assign w_load        = ((r_state == c_ST_IDLE) & w_arb.valid) | w_nmi_preempt;

    always_comb begin
        w_clr = 4'b0000;
        if (w_take) begin
            case (r_inter_sel)
                c_CAUSE_NMI:    w_clr[0] = 1'b1;
                c_CAUSE_ECALL:  w_clr[1] = 1'b1;
                c_CAUSE_EBREAK: w_clr[2] = 1'b1;
                c_CAUSE_TMR:    w_clr[3] = 1'b1;
                default:        w_clr    = 4'b0000;  // external lines are not latched
            endcase
        end
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_arb.valid) w_state_nxt = c_ST_REQ;
            end
            c_ST_REQ: begin
                if (irq_if.take_ack) w_state_nxt = c_ST_SERVICE;
            end
            c_ST_SERVICE: begin
                if (irq_if.mret) begin
                    w_state_nxt = (r_nmi_active & r_nmi_preempt) ? c_ST_SERVICE : c_ST_IDLE;
                end else if (w_nmi_preempt) begin
                    w_state_nxt = c_ST_REQ;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        irq_if.interruptF = (r_state == c_ST_REQ);
        irq_if.in_service = w_in_svc;
    end

    // ---------------- Datapath registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_nmi_q       <= 1'b0;
            r_pend        <= 4'b0000;
            r_nmi_active  <= 1'b0;
            r_nmi_preempt <= 1'b0;
            r_inter_sel   <= c_CAUSE_NMI;
            r_int_num     <= 1'b0;
        end else begin
            r_nmi_q <= irq_if.nmi;
            // set wins over a simultaneous clear
            r_pend  <= (r_pend & ~w_clr) | w_set;

            if (w_load) begin
                r_inter_sel <= w_arb.sel;
                r_int_num   <= w_arb.num;
            end

            if (w_take && (r_inter_sel == c_CAUSE_NMI)) begin
                r_nmi_active <= 1'b1;
            end else if (w_in_svc && irq_if.mret && r_nmi_active) begin
                r_nmi_active <= 1'b0;
            end

            if (w_nmi_preempt) begin
                r_nmi_preempt <= 1'b1;
            end else if (w_in_svc && irq_if.mret && r_nmi_active) begin
                r_nmi_preempt <= 1'b0;
            end
        end
    end

    assign irq_if.interSel = r_inter_sel;
    assign irq_if.intNum   = r_int_num;
    assign irq_if.pending  = {|w_ext_req, r_pend};

endmodule

`default_nettype wire

// File: tb/tb_interrupt_controller.sv
// ============================================================================
// Module      : tb_interrupt_controller
// Description : Self-checking bench for interrupt_controller. A handler-stack
//               model predicts every output each cycle; directed scenarios
//               add literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_interrupt_controller;

    logic clk = 1'b0;
    logic rst;

    interrupt_controller_if ifc ();

    interrupt_controller dut (
        .clk    (clk),
        .rst    (rst),
        .irq_if (ifc)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- Reference model ----------------
    // mode: 0 idle, 1 request outstanding, 2 servicing.
    // m_stack holds the cause codes of the handlers currently running.
    int       m_mode     = 0;
    bit [3:0] m_pend     = 4'b0000;   // {tmr, ebreak, ecall, nmi}
    bit       m_nmi_prev = 1'b0;
    int       m_sel      = 0;
    int       m_num      = 0;
    int       m_stack[$];

    always @(posedge clk) begin
        bit [3:0] s;
        bit [3:0] eff;
        bit [1:0] ext;
        bit       ok[6];
        bit       svc;
        bit       has_nmi;
        bit       found;
        int       clr;
        if (rst) begin
            m_mode     = 0;
            m_pend     = 4'b0000;
            m_nmi_prev = 1'b0;
            m_sel      = 0;
            m_num      = 0;
            m_stack.delete();
        end else begin
            s[0] = ifc.nmi && !m_nmi_prev;
            s[1] = ifc.ecall;
            s[2] = ifc.ebreak;
            s[3] = ifc.tmr_irq;
            eff  = m_pend | s;
            ext  = ifc.ext_irq & {2{ifc.eie}};
            svc  = (m_mode == 2);
            ok[0] = eff[0];
            ok[1] = eff[1] && !svc;
            ok[2] = eff[2] && !svc;
            ok[3] = eff[3] && ifc.tie && ifc.mie && !svc;
            ok[4] = ext[0] && ifc.mie && !svc;
            ok[5] = ext[1] && ifc.mie && !svc;
            clr = -1;
            has_nmi = 1'b0;
            foreach (m_stack[i]) if (m_stack[i] == 0) has_nmi = 1'b1;
            found = 1'b0;
            case (m_mode)
                0: begin
                    for (int i = 0; i < 6; i++) begin
                        if (ok[i] && !found) begin
                            found  = 1'b1;
                            m_sel  = (i >= 4) ? 4 : i;
                            m_num  = (i == 5) ? 1 : 0;
                            m_mode = 1;
                        end
                    end
                end
                1: begin
                    if (ifc.take_ack) begin
                        if (m_sel < 4) clr = m_sel;
                        m_stack.push_back(m_sel);
                        m_mode = 2;
                    end
                end
                default: begin
                    if (ifc.mret) begin
                        void'(m_stack.pop_back());
                        if (m_stack.size() == 0) m_mode = 0;
                    end else if (ok[0] && !has_nmi) begin
                        m_mode = 1;
                        m_sel  = 0;
                        m_num  = 0;
                    end
                end
            endcase
            for (int i = 0; i < 4; i++) begin
                m_pend[i] = (m_pend[i] && (clr != i)) || s[i];
            end
            m_nmi_prev = ifc.nmi;
        end
    end

    // ---------------- Per-cycle comparison ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("interruptF", ifc.interruptF, 8'(m_mode == 1));
            chk("in_service", ifc.in_service, 8'(m_mode == 2));
            chk("interSel",   ifc.interSel,   8'(m_sel[2:0]));
            chk("intNum",     ifc.intNum,     8'(m_num[0]));
            chk("pending",    ifc.pending,    8'({|(ifc.ext_irq & {2{ifc.eie}}), m_pend}));
        end
    end

    // Advance to the drive window just after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst          = 1'b1;
        ifc.nmi      = 1'b0;
        ifc.ecall    = 1'b0;
        ifc.ebreak   = 1'b0;
        ifc.tmr_irq  = 1'b0;
        ifc.ext_irq  = 2'b00;
        ifc.mie      = 1'b0;
        ifc.tie      = 1'b0;
        ifc.eie      = 1'b0;
        ifc.take_ack = 1'b0;
        ifc.mret     = 1'b0;
        cyc();
        chk_en = 1'b1;
        cyc();
        chk("rst_interruptF", ifc.interruptF, 8'd0);
        chk("rst_in_service", ifc.in_service, 8'd0);
        chk("rst_pending",    ifc.pending,    8'd0);
        rst = 1'b0;
        ifc.mie = 1'b1;
        ifc.tie = 1'b1;
        repeat (3) cyc();

        // Timer request, ack two cycles later
        ifc.tmr_irq = 1'b1;
        cyc();
        ifc.tmr_irq = 1'b0;
        chk("tmr_interruptF", ifc.interruptF, 8'd1);
        chk("tmr_interSel",   ifc.interSel,   8'd3);
        chk("model_tmr_sel",  8'(m_sel),      8'd3);
        cyc();
        ifc.take_ack = 1'b1;
        cyc();
        ifc.take_ack = 1'b0;
        chk("tmr_ack_interruptF", ifc.interruptF, 8'd0);
        chk("tmr_ack_in_service", ifc.in_service, 8'd1);
        chk("model_tmr_mode",     8'(m_mode),     8'd2);
        ifc.mret = 1'b1;
        cyc();
        ifc.mret = 1'b0;
        chk("tmr_mret_in_service", ifc.in_service, 8'd0);

        // ECALL beats a simultaneous timer pulse
        ifc.ecall   = 1'b1;
        ifc.tmr_irq = 1'b1;
        cyc();
        ifc.ecall   = 1'b0;
        ifc.tmr_irq = 1'b0;
        chk("ecall_first_sel", ifc.interSel, 8'd1);
        ifc.take_ack = 1'b1;
        cyc();
        ifc.take_ack = 1'b0;
        chk("ecall_svc_pending", ifc.pending, 8'b01000);
        ifc.mret = 1'b1;
        cyc();
        ifc.mret = 1'b0;
        chk("ecall_mret_interruptF", ifc.interruptF, 8'd0);
        cyc();
        chk("tmr_second_interruptF", ifc.interruptF, 8'd1);
        chk("tmr_second_sel",        ifc.interSel,   8'd3);
        ifc.take_ack = 1'b1;
        cyc();
        ifc.take_ack = 1'b0;
        ifc.mret = 1'b1;
        cyc();
        ifc.mret = 1'b0;

        // External lines, line 0 above line 1
        ifc.eie     = 1'b1;
        ifc.ext_irq = 2'b11;
        cyc();
        chk("ext_sel",  ifc.interSel, 8'd4);
        chk("ext_num0", ifc.intNum,   8'd0);
        ifc.take_ack = 1'b1;
        cyc();
        ifc.take_ack = 1'b0;
        ifc.ext_irq  = 2'b10;
        ifc.mret     = 1'b1;
        cyc();
        ifc.mret = 1'b0;
        cyc();
        chk("ext_num1", ifc.intNum,   8'd1);
        chk("ext_sel1", ifc.interSel, 8'd4);
        ifc.take_ack = 1'b1;
        ifc.ext_irq  = 2'b00;
        cyc();
        ifc.take_ack = 1'b0;
        ifc.mret     = 1'b1;
        cyc();
        ifc.mret = 1'b0;

        // NMI pre-empts a timer handler; held-high NMI does not re-fire
        ifc.tmr_irq = 1'b1;
        cyc();
        ifc.tmr_irq  = 1'b0;
        ifc.take_ack = 1'b1;
        cyc();
        ifc.take_ack = 1'b0;
        ifc.nmi      = 1'b1;
        cyc();
        chk("nmi_interruptF", ifc.interruptF, 8'd1);
        chk("nmi_sel",        ifc.interSel,   8'd0);
        ifc.take_ack = 1'b1;
        cyc();
        ifc.take_ack = 1'b0;
        chk("nmi_in_service", ifc.in_service, 8'd1);
        ifc.mret = 1'b1;
        cyc();
        ifc.mret = 1'b0;
        chk("nmi_mret1_in_service", ifc.in_service, 8'd1);
        cyc();
        chk("nmi_mret1_interruptF", ifc.interruptF, 8'd0);
        ifc.mret = 1'b1;
        cyc();
        ifc.mret = 1'b0;
        chk("nmi_mret2_in_service", ifc.in_service, 8'd0);
        repeat (2) cyc();
        chk("nmi_held_no_refire", ifc.interruptF, 8'd0);
        ifc.nmi = 1'b0;
        cyc();

        // Pulse coinciding with its own ack leaves the bit set
        ifc.ecall = 1'b1;
        cyc();
        ifc.take_ack = 1'b1;
        cyc();
        ifc.ecall    = 1'b0;
        ifc.take_ack = 1'b0;
        chk("set_wins_pending", ifc.pending, 8'b00010);
        ifc.mret = 1'b1;
        cyc();
        ifc.mret = 1'b0;
        cyc();
        chk("set_wins_rereq", ifc.interSel, 8'd1);
        ifc.take_ack = 1'b1;
        cyc();
        ifc.take_ack = 1'b0;
        ifc.mret     = 1'b1;
        cyc();
        ifc.mret = 1'b0;

        // Reset while a request is outstanding
        ifc.ecall = 1'b1;
        cyc();
        ifc.ecall  = 1'b0;
        ifc.ebreak = 1'b1;
        cyc();
        ifc.ebreak = 1'b0;
        chk("pre_rst_pending",    ifc.pending,    8'b00110);
        chk("pre_rst_interruptF", ifc.interruptF, 8'd1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("post_rst_interruptF", ifc.interruptF, 8'd0);
        chk("post_rst_interSel",   ifc.interSel,   8'd0);
        chk("post_rst_intNum",     ifc.intNum,     8'd0);
        chk("post_rst_in_service", ifc.in_service, 8'd0);
        chk("post_rst_pending",    ifc.pending,    8'd0);
        cyc();

        // Randomized traffic checked by the model
        for (int c = 0; c < 4000; c++) begin
            rst          = ($urandom_range(0, 299) == 0);
            ifc.ecall    = ($urandom_range(0, 9) == 0);
            ifc.ebreak   = ($urandom_range(0, 9) == 0);
            ifc.tmr_irq  = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 19) == 0) ifc.nmi = ~ifc.nmi;
            if ($urandom_range(0, 14) == 0) ifc.ext_irq = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 49) == 0) begin
                ifc.mie = ($urandom_range(0, 3) != 0);
                ifc.tie = ($urandom_range(0, 3) != 0);
                ifc.eie = ($urandom_range(0, 3) != 0);
            end
            ifc.take_ack = ($urandom_range(0, 2) == 0);
            ifc.mret     = ($urandom_range(0, 5) == 0);
            cyc();
        end

        rst          = 1'b0;
        ifc.ecall    = 1'b0;
        ifc.ebreak   = 1'b0;
        ifc.tmr_irq  = 1'b0;
        ifc.take_ack = 1'b0;
        ifc.mret     = 1'b0;
        repeat (3) cyc();
        @(negedge clk);
        #1;
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
